// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl
//   Pipeline sequencing controller for the 16-bit five-stage core. It sits
//   beside Execute, owns the architectural compare flags, resolves conditional
//   jumps in EX, and produces every stall/bubble/flush control from one FSM.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid/opcode/src1/src2  instruction currently in ID
//   ex_valid/opcode/dest       instruction currently in EX
//   ex_zf, ex_gf, ex_lf        compare results for the EX instruction
//   mem_valid, mem_ready       data-memory access in MEM and its completion
//   pc_stall, if_id_stall      hold PC / IF-ID
//   id_ex_bubble               load NOP into ID/EX
//   ex_mem_stall               hold EX/MEM and everything upstream
//   if_id_flush                replace IF/ID with NOP
//   take_branch                select jump target (one-cycle pulse)
//   flag_zf, flag_gf, flag_lf  architectural flags
//   state                      FSM state (RUN=0 LDUSE=1 FLUSH=2 MWAIT=3)
//
// Optional build macro HAZARD_STALL_COUNT_EN adds saturating 16-bit counters
//   stall_cnt (cycles with pc_stall) and flush_cnt (cycles with if_id_flush).
module ex_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int OPW          = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           id_valid,
  input  logic [OPW-1:0] id_opcode,
  input  logic [4:0]     id_src1,
  input  logic [4:0]     id_src2,
  input  logic           ex_valid,
  input  logic [OPW-1:0] ex_opcode,
  input  logic [4:0]     ex_dest,
  input  logic           ex_zf,
  input  logic           ex_gf,
  input  logic           ex_lf,
  input  logic           mem_valid,
  input  logic           mem_ready,
  output logic           pc_stall,
  output logic           if_id_stall,
  output logic           id_ex_bubble,
  output logic           ex_mem_stall,
  output logic           if_id_flush,
  output logic           take_branch,
  output logic           flag_zf,
  output logic           flag_gf,
  output logic           flag_lf,
  output logic [1:0]     state
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [15:0]    stall_cnt,
  output logic [15:0]    flush_cnt
`endif
);

  localparam logic [OPW-1:0] OP_SUB    = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD    = OPW'(2);
  localparam logic [OPW-1:0] OP_ADDI   = OPW'(3);
  localparam logic [OPW-1:0] OP_SHLLI  = OPW'(4);
  localparam logic [OPW-1:0] OP_SHRLI  = OPW'(5);
  localparam logic [OPW-1:0] OP_JUMP   = OPW'(6);
  localparam logic [OPW-1:0] OP_JUMPL  = OPW'(7);
  localparam logic [OPW-1:0] OP_JUMPG  = OPW'(8);
  localparam logic [OPW-1:0] OP_JUMPE  = OPW'(9);
  localparam logic [OPW-1:0] OP_JUMPNE = OPW'(10);
  localparam logic [OPW-1:0] OP_CMP    = OPW'(11);
  localparam logic [OPW-1:0] OP_LOAD   = OPW'(12);
  localparam logic [OPW-1:0] OP_STORE  = OPW'(14);
  localparam logic [OPW-1:0] OP_MOV    = OPW'(15);

  // The jump cycle itself is the first flush cycle; the counter covers the rest.
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LDUSE = 2'd1,
    ST_FLUSH = 2'd2,
    ST_MWAIT = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       saved_flush_q, saved_flush_d;  // state to resume after MWAIT
  logic [2:0] flags_q, flags_d;              // {zf, gf, lf}

  logic uses_src1, uses_src2, load_use, taken, mem_wait;

  always_comb begin
    uses_src1 = (id_opcode == OP_SUB)   || (id_opcode == OP_ADD)   ||
                (id_opcode == OP_ADDI)  || (id_opcode == OP_SHLLI) ||
                (id_opcode == OP_SHRLI) || (id_opcode == OP_CMP)   ||
                (id_opcode == OP_STORE) || (id_opcode == OP_MOV);
    uses_src2 = (id_opcode == OP_SUB)   || (id_opcode == OP_ADD)   ||
                (id_opcode == OP_CMP)   || (id_opcode == OP_STORE);
    load_use  = ex_valid && (ex_opcode == OP_LOAD) && id_valid &&
                ((uses_src1 && (id_src1 == ex_dest)) ||
                 (uses_src2 && (id_src2 == ex_dest)));
    mem_wait  = mem_valid && !mem_ready;
    taken     = 1'b0;
    if (ex_valid) begin
      case (ex_opcode)
        OP_JUMP:   taken = 1'b1;
        OP_JUMPL:  taken = flags_q[0];
        OP_JUMPG:  taken = flags_q[1];
        OP_JUMPE:  taken = flags_q[2];
        OP_JUMPNE: taken = !flags_q[2];
        default:   taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    logic resolve, in_flush;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_stall  = 1'b0;
    if_id_flush   = 1'b0;
    take_branch   = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;
    saved_flush_d = saved_flush_q;
    resolve       = 1'b1;
    in_flush      = 1'b0;

    // On the MWAIT release cycle the saved state's rules apply, so a jump
    // held in EX resolves in the same cycle the stall drops.
    case (state_q)
      ST_MWAIT: begin
        if (!mem_ready) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          ex_mem_stall = 1'b1;
          resolve      = 1'b0;
        end else begin
          in_flush = saved_flush_q;
        end
      end
      ST_FLUSH: in_flush = 1'b1;
      default:  in_flush = 1'b0;
    endcase

    if (resolve) begin
      if (mem_wait) begin
        // Flush counter is left untouched so the flush resumes afterwards.
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        ex_mem_stall  = 1'b1;
        saved_flush_d = in_flush;
        state_d       = ST_MWAIT;
      end else if (in_flush) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        cnt_d        = cnt_q - 2'd1;
        state_d      = (cnt_q == 2'd1) ? ST_RUN : ST_FLUSH;
      end else if (taken) begin
        take_branch = 1'b1;
        if_id_flush = 1'b1;
        cnt_d       = FLUSH_LOAD;
        state_d     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
      end else if (load_use) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
        state_d      = ST_LDUSE;
      end else begin
        state_d = ST_RUN;
      end
    end

    // No control pulse may leak out while reset is held.
    if (!rst_n) begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_stall = 1'b0;
      if_id_flush  = 1'b0;
      take_branch  = 1'b0;
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (ex_valid && (ex_opcode == OP_CMP) && !ex_mem_stall)
      flags_d = {ex_zf, ex_gf, ex_lf};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      cnt_q         <= 2'd0;
      saved_flush_q <= 1'b0;
      flags_q       <= 3'b000;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      saved_flush_q <= saved_flush_d;
      flags_q       <= flags_d;
    end
  end

  assign flag_zf = flags_q[2];
  assign flag_gf = flags_q[1];
  assign flag_lf = flags_q[0];
  assign state   = state_q;

`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && (stall_cnt_q != 16'hFFFF))    stall_cnt_d = stall_cnt_q + 16'd1;
    if (if_id_flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
